// File: rtl/counter_91.sv
// counter_91: loadable 7-bit down-counter raising dn COUNT+1 edges after the most recent ld.
// Defining COUNTER_91_REMAIN_EN adds the registered rem output (remaining count while running).
module counter_91 #(
   parameter int unsigned COUNT = 91
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld,
   output logic       dn
`ifdef COUNTER_91_REMAIN_EN
   ,
   output logic [6:0] rem
`endif
);

   localparam logic [6:0] LOAD_VAL = 7'(COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   logic [6:0] cnt_r;
   logic       dn_r;
   logic       run_s;

   assign run_s = (state_r == RUN);
   assign dn    = dn_r;

   // Main sequencer: a load always wins, otherwise count down and flag done once cnt has hit zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 7'd0;
         dn_r    <= 1'b0;
      end else if (ld) begin
         state_r <= RUN;
         cnt_r   <= LOAD_VAL;
         dn_r    <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (cnt_r != 7'd0) begin
                  cnt_r <= cnt_r - 7'd1;
               end else begin
                  state_r <= DONE;
                  dn_r    <= 1'b1;
               end
            end
            IDLE: begin
               state_r <= IDLE;
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 7'd0;
               dn_r    <= 1'b0;
            end
         endcase
      end
   end

`ifdef COUNTER_91_REMAIN_EN
   logic [6:0] rem_r;

   assign rem = rem_r;

   // Remaining-count register tracks the next value of cnt while running and reads 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r <= 7'd0;
      end else if (ld) begin
         rem_r <= LOAD_VAL;
      end else if (run_s && (cnt_r != 7'd0)) begin
         rem_r <= cnt_r - 7'd1;
      end else begin
         rem_r <= 7'd0;
      end
   end
`endif

   counter_91_chk #(
      .LOAD_VAL (LOAD_VAL)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .run   (run_s),
      .dn    (dn_r),
      .cnt   (cnt_r)
   );

endmodule

// counter_91_chk: structural invariants of the counter state.
module counter_91_chk #(
   parameter logic [6:0] LOAD_VAL = 7'd91
) (
   input logic       clk,
   input logic       rst_n,
   input logic       ld,
   input logic       run,
   input logic       dn,
   input logic [6:0] cnt
);

   a_run_dn_excl : assert property (@(posedge clk) disable iff (!rst_n) !(run && dn));
   a_cnt_bound   : assert property (@(posedge clk) disable iff (!rst_n) cnt <= LOAD_VAL);
   a_done_zero   : assert property (@(posedge clk) disable iff (!rst_n) dn |-> (cnt == 7'd0));
   a_ld_clears   : assert property (@(posedge clk) disable iff (!rst_n) ld |=> !dn);

endmodule

// File: tb/tb_counter_91.sv
// tb_counter_91: directed vectors feed an expectation queue; a monitor pops and compares each cycle.
// Set COUNTER_91_REMAIN_EN to also check the rem output.
module tb_counter_91;

   logic       clk;
   logic       rst_n;
   logic       ld;
   logic       dn;
`ifdef COUNTER_91_REMAIN_EN
   logic [6:0] rem;
`endif

   int n_vec;
   int n_err;

   logic       exp_dn_q[$];
   logic [6:0] exp_rem_q[$];
   string      tag_q[$];

   counter_91 #(.COUNT(91)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .dn    (dn)
`ifdef COUNTER_91_REMAIN_EN
      ,
      .rem   (rem)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue the expectation for the next rising edge and drive ld for it.
   task automatic drive(input logic l, input logic e_dn, input logic [6:0] e_rem, input string tag);
      ld = l;
      exp_dn_q.push_back(e_dn);
      exp_rem_q.push_back(e_rem);
      tag_q.push_back(tag);
   endtask

   task automatic step(input logic l, input logic e_dn, input logic [6:0] e_rem, input string tag);
      @(negedge clk);
      drive(l, e_dn, e_rem, tag);
   endtask

   // Immediate (clockless) check used around asynchronous reset.
   task automatic check_now(input string tag);
      n_vec++;
      if (dn !== 1'b0) begin
         n_err++;
         $display("FAIL %s: dn=%0b expected 0", tag, dn);
      end
`ifdef COUNTER_91_REMAIN_EN
      if (rem !== 7'd0) begin
         n_err++;
         $display("FAIL %s: rem=%0d expected 0", tag, rem);
      end
`endif
   endtask

   // From a load edge already issued: 91 counting edges, then dn rises on the 92nd.
   task automatic run_to_done(input string tag);
      for (int k = 1; k <= 91; k++) step(1'b0, 1'b0, 7'(91 - k), tag);
      step(1'b0, 1'b1, 7'd0, {tag, "_rise"});
   endtask

   // Monitor: compare one queued expectation just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_dn_q.size() > 0) begin
            logic       e_dn;
            logic [6:0] e_rem;
            string      t;
            e_dn  = exp_dn_q.pop_front();
            e_rem = exp_rem_q.pop_front();
            t     = tag_q.pop_front();
            n_vec++;
            if (dn !== e_dn) begin
               n_err++;
               $display("FAIL %s: dn=%0b expected %0b at %0t", t, dn, e_dn, $time);
            end
`ifdef COUNTER_91_REMAIN_EN
            if (rem !== e_rem) begin
               n_err++;
               $display("FAIL %s: rem=%0d expected %0d at %0t", t, rem, e_rem, $time);
            end
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      ld    = 1'b0;
      #12;
      check_now("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle edges without load never start counting.
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 7'd0, "idle");

      // Single load pulse, full count, then DONE holds.
      step(1'b1, 1'b0, 7'd91, "load1");
      run_to_done("count1");
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 7'd0, "done_hold");

      // Load during DONE clears dn on the same edge and restarts.
      step(1'b1, 1'b0, 7'd91, "reload_done");
      run_to_done("count2");

      // Reload 40 edges after the first load: only the second load times out.
      step(1'b1, 1'b0, 7'd91, "loadA");
      for (int k = 1; k <= 39; k++) step(1'b0, 1'b0, 7'(91 - k), "partial");
      step(1'b1, 1'b0, 7'd91, "loadB");
      run_to_done("count3");

      // ld held high for 3 edges reloads each time.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 7'd91, "ld_held");
      run_to_done("count4");

      // Reset mid-count aborts; block stays idle afterwards.
      step(1'b1, 1'b0, 7'd91, "load_rst");
      for (int k = 1; k <= 49; k++) step(1'b0, 1'b0, 7'(91 - k), "pre_rst");
      @(negedge clk);
      ld    = 1'b0;
      rst_n = 1'b0;
      #1;
      check_now("rst_midcount");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 200; k++) step(1'b0, 1'b0, 7'd0, "post_rst_idle");

      // Reset while in DONE drops dn without a clock.
      step(1'b1, 1'b0, 7'd91, "load5");
      run_to_done("count5");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_now("rst_in_done");
      @(negedge clk);
      @(negedge clk);

      // Load on the very first edge after release is honoured.
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 7'd91, "load_first_edge");
      run_to_done("count6");
      step(1'b0, 1'b1, 7'd0, "final_hold");

      // Drain the expectation queue within a bounded number of edges.
      for (int k = 0; k < 5 && exp_dn_q.size() > 0; k++) @(posedge clk);
      #2;
      n_vec++;
      if (exp_dn_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_dn_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
